// File: rtl/debounce_filter_pkg.sv
// Shared definitions for the debounce filter: state encoding, default
// parameter set (also used by the edge_detect bench) and a width helper.
package debounce_pkg;

    // State encoding of the qualification FSM
    localparam logic ST_STABLE  = 1'b0;
    localparam logic ST_QUALIFY = 1'b1;

    typedef enum logic {
        STABLE  = ST_STABLE,
        QUALIFY = ST_QUALIFY
    } state_e;

    // Default parameter set, kept in one place so the downstream
    // edge_detect bench drives the filter exactly as the system does.
    localparam int unsigned DEF_SYNC_STAGES   = 2;
    localparam int unsigned DEF_STABLE_CYCLES = 4;
    localparam logic        DEF_RESET_VAL     = 1'b0;
    localparam int unsigned DEF_GLITCH_W      = 8;

    typedef struct packed {
        int unsigned sync_stages;
        int unsigned stable_cycles;
        logic        reset_val;
        int unsigned glitch_w;
    } debounce_cfg_t;

    localparam debounce_cfg_t DEFAULT_CFG = '{
        sync_stages:   DEF_SYNC_STAGES,
        stable_cycles: DEF_STABLE_CYCLES,
        reset_val:     DEF_RESET_VAL,
        glitch_w:      DEF_GLITCH_W
    };

    // Width of the qualify counter; it only ever holds 0..STABLE_CYCLES-1,
    // the +1 keeps a 1-bit counter legal when STABLE_CYCLES is 1.
    function automatic int unsigned cnt_width(input int unsigned stable_cycles);
        return $clog2(stable_cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_filter_if.sv
// Level/diagnostic bundle between the pin-side driver and the debounce filter.
interface debounce_filter_if
    import debounce_pkg::*;
#(
    parameter int unsigned GLITCH_W = DEF_GLITCH_W
);
    logic                raw_in;
    logic                glitch_clr;
    logic                db_out;
    logic                busy;
    logic [GLITCH_W-1:0] glitch_cnt;

    // Driver of the raw level and clear request; observes the filtered result
    modport master (
        output raw_in,
        output glitch_clr,
        input  db_out,
        input  busy,
        input  glitch_cnt
    );

    // The filter itself
    modport slave (
        input  raw_in,
        input  glitch_clr,
        output db_out,
        output busy,
        output glitch_cnt
    );
endinterface

// File: rtl/debounce_filter_sync.sv
// Plain multi-flop synchroniser for a single asynchronous level.
// Nothing may sit between the stages, so this module holds flops only.
module sync_chain #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] chain_q;

    // Shift the raw level through the chain; reset preloads the idle level
    always_ff @(posedge clk) begin
        if (rst) begin
            chain_q <= {STAGES{RESET_VAL}};
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d};
        end
    end

    assign q = chain_q[STAGES-1];
endmodule

// File: rtl/debounce_filter.sv
// Debounce filter: synchronises raw_in, then commits a new level only after
// it has been seen for STABLE_CYCLES consecutive clocks. Aborted candidates
// are counted in a saturating glitch counter. SYNC_STAGES must be >= 2 and
// STABLE_CYCLES >= 1.
module debounce_filter
    import debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter logic        RESET_VAL     = DEF_RESET_VAL,
    parameter int unsigned GLITCH_W      = DEF_GLITCH_W
) (
    input  logic               clk,
    input  logic               rst,
    debounce_filter_if.slave   bus
);
    localparam int unsigned          CNT_W      = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]     CNT_LAST   = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [GLITCH_W-1:0]  GLITCH_MAX = '1;

    logic                sync_s;
    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                db_q, db_d;
    logic [GLITCH_W-1:0] glitch_q, glitch_d;
    logic                abort;

    sync_chain #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (RESET_VAL)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.raw_in),
        .q   (sync_s)
    );

    // Qualification decision: start, extend, commit or abort a candidate level
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        db_d    = db_q;
        abort   = 1'b0;
        case (state_q)
            STABLE: begin
                cnt_d = '0;
                if (sync_s != db_q) begin
                    if (STABLE_CYCLES == 1) begin
                        db_d = sync_s;
                    end else begin
                        cnt_d   = CNT_W'(1);
                        state_d = QUALIFY;
                    end
                end
            end
            QUALIFY: begin
                if (sync_s == db_q) begin
                    cnt_d   = '0;
                    state_d = STABLE;
                    abort   = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    db_d    = sync_s;
                    cnt_d   = '0;
                    state_d = STABLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    // Glitch counter: clear wins over a same-cycle abort, otherwise saturate
    always_comb begin
        glitch_d = glitch_q;
        if (bus.glitch_clr) begin
            glitch_d = '0;
        end else if (abort && (glitch_q != GLITCH_MAX)) begin
            glitch_d = glitch_q + GLITCH_W'(1);
        end
    end

    // State, counters and the debounced level; reset drops any candidate silently
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= STABLE;
            cnt_q    <= '0;
            db_q     <= RESET_VAL;
            glitch_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            db_q     <= db_d;
            glitch_q <= glitch_d;
        end
    end

    assign bus.db_out     = db_q;
    assign bus.busy       = (state_q == QUALIFY);
    assign bus.glitch_cnt = glitch_q;
endmodule

// File: tb/tb_debounce_filter.sv
// Bench for debounce_filter: directed scenarios plus a randomized run,
// checked against a window-based behavioural model of the filter.
module tb_debounce_filter;
    localparam int SYNC   = 2;
    localparam int STABLE = 4;
    localparam int GW     = 8;
    localparam bit RV     = 1'b0;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    debounce_filter_if #(.GLITCH_W(GW)) bus ();

    debounce_filter #(
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STABLE),
        .RESET_VAL     (RV),
        .GLITCH_W      (GW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference model: raw samples delayed by the synchroniser depth, and a
    // window of the last STABLE samples the filter decided on. A new level
    // commits when the whole window disagrees with the current output.
    bit mRaw [SYNC];
    bit mSmp [$];
    bit mDb;
    bit mBusy;
    int mGlitch;

    task automatic step();
        bit s;
        bit abort;
        bit allDiff;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < SYNC; i++) mRaw[i] = RV;
            mSmp.delete();
            mDb     = RV;
            mBusy   = 1'b0;
            mGlitch = 0;
        end else begin
            s = mRaw[SYNC-1];
            for (int i = SYNC - 1; i > 0; i--) mRaw[i] = mRaw[i-1];
            mRaw[0] = bus.raw_in;
            abort = mBusy && (s == mDb);
            mSmp.push_back(s);
            if (mSmp.size() > STABLE) void'(mSmp.pop_front());
            allDiff = (mSmp.size() == STABLE);
            foreach (mSmp[i]) if (mSmp[i] == mDb) allDiff = 1'b0;
            if (allDiff) mDb = s;
            if (bus.glitch_clr) mGlitch = 0;
            else if (abort && mGlitch < (1 << GW) - 1) mGlitch++;
            mBusy = (s != mDb);
        end
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.raw_in = 1'b0;
        bus.glitch_clr = 1'b0;
        steps(2);
        compared++;
        if (bus.db_out !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_db: got %0b expected 0", bus.db_out);
        end
        compared++;
        if (bus.busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_busy: got %0b expected 0", bus.busy);
        end
        compared++;
        if (bus.glitch_cnt !== 8'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_glitch: got %0d expected 0", bus.glitch_cnt);
        end
        rst = 1'b0;
        steps(2);
    endtask

    task automatic test_press();
        bit expBusy;
        bit expDb;
        bus.raw_in = 1'b1;
        for (int e = 0; e < 8; e++) begin
            step();
            expBusy = (e >= 2 && e <= 4);
            expDb   = (e >= 5);
            compared++;
            if (bus.busy !== expBusy) begin
                mismatched++;
                $display("[TB] FAIL press_busy_e%0d: got %0b expected %0b", e, bus.busy, expBusy);
            end
            compared++;
            if (bus.db_out !== expDb) begin
                mismatched++;
                $display("[TB] FAIL press_db_e%0d: got %0b expected %0b", e, bus.db_out, expDb);
            end
        end
        bus.raw_in = 1'b0;
        steps(8);
        compared++;
        if (bus.db_out !== 1'b0 || bus.glitch_cnt !== 8'd0) begin
            mismatched++;
            $display("[TB] FAIL release_db: got db=%0b glitch=%0d expected db=0 glitch=0",
                     bus.db_out, bus.glitch_cnt);
        end
    endtask

    task automatic test_glitch();
        bit sawBusy = 1'b0;
        bit sawDb = 1'b0;
        bus.raw_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) bus.raw_in = 1'b0;
            step();
            if (bus.busy === 1'b1) sawBusy = 1'b1;
            if (bus.db_out !== 1'b0) sawDb = 1'b1;
        end
        compared++;
        if (sawDb !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL glitch_db: got db change %0b expected 0", sawDb);
        end
        compared++;
        if (sawBusy !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL glitch_busy_seen: got %0b expected 1", sawBusy);
        end
        compared++;
        if (bus.glitch_cnt !== 8'd1 || bus.busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL glitch_cnt: got cnt=%0d busy=%0b expected cnt=1 busy=0",
                     bus.glitch_cnt, bus.busy);
        end
    endtask

    task automatic test_saturation_clear();
        for (int g = 0; g < 300; g++) begin
            bus.raw_in = 1'b1;
            steps(2);
            bus.raw_in = 1'b0;
            steps(5);
        end
        compared++;
        if (bus.glitch_cnt !== 8'd255) begin
            mismatched++;
            $display("[TB] FAIL glitch_saturate: got %0d expected 255", bus.glitch_cnt);
        end
        compared++;
        if (bus.glitch_cnt !== mGlitch[GW-1:0]) begin
            mismatched++;
            $display("[TB] FAIL glitch_saturate_model: got %0d expected %0d", bus.glitch_cnt, mGlitch);
        end
        bus.raw_in = 1'b1;
        steps(2);
        bus.raw_in = 1'b0;
        steps(2);
        compared++;
        if (bus.busy !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL clear_pre_busy: got %0b expected 1", bus.busy);
        end
        bus.glitch_clr = 1'b1;
        step();
        bus.glitch_clr = 1'b0;
        compared++;
        if (bus.glitch_cnt !== 8'd0 || bus.busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL clear_vs_abort: got cnt=%0d busy=%0b expected cnt=0 busy=0",
                     bus.glitch_cnt, bus.busy);
        end
        steps(3);
    endtask

    task automatic test_reset_mid_qualify();
        bus.raw_in = 1'b1;
        steps(2);
        bus.raw_in = 1'b0;
        steps(6);
        bus.raw_in = 1'b1;
        steps(3);
        compared++;
        if (bus.busy !== 1'b1 || bus.glitch_cnt !== 8'd1) begin
            mismatched++;
            $display("[TB] FAIL midq_pre: got busy=%0b cnt=%0d expected busy=1 cnt=1",
                     bus.busy, bus.glitch_cnt);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        compared++;
        if (bus.db_out !== 1'b0 || bus.busy !== 1'b0 || bus.glitch_cnt !== 8'd0) begin
            mismatched++;
            $display("[TB] FAIL midq_reset: got db=%0b busy=%0b cnt=%0d expected 0/0/0",
                     bus.db_out, bus.busy, bus.glitch_cnt);
        end
        for (int e = 1; e <= 6; e++) begin
            step();
            compared++;
            if (bus.db_out !== (e == 6)) begin
                mismatched++;
                $display("[TB] FAIL midq_release_e%0d: got %0b expected %0b", e, bus.db_out, (e == 6));
            end
        end
        compared++;
        if (bus.glitch_cnt !== 8'd0) begin
            mismatched++;
            $display("[TB] FAIL midq_glitch: got %0d expected 0", bus.glitch_cnt);
        end
        bus.raw_in = 1'b0;
        steps(8);
    endtask

    task automatic test_bounce();
        int rises = 0;
        int falls = 0;
        logic prev;
        prev = bus.db_out;
        bus.raw_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (!prev && bus.db_out) rises++;
            if (prev && !bus.db_out) falls++;
            prev = bus.db_out;
        end
        compared++;
        if (rises !== 1 || falls !== 0) begin
            mismatched++;
            $display("[TB] FAIL clean_press: got rise=%0d down=%0d expected rise=1 down=0", rises, falls);
        end
        bus.raw_in = 1'b0;
        steps(10);
        rises = 0;
        falls = 0;
        prev = bus.db_out;
        for (int i = 0; i < 20; i++) begin
            bus.raw_in = (i < 5) ? ((i % 2) == 0) : 1'b1;
            step();
            if (!prev && bus.db_out) rises++;
            if (prev && !bus.db_out) falls++;
            prev = bus.db_out;
        end
        compared++;
        if (rises !== 1 || falls !== 0) begin
            mismatched++;
            $display("[TB] FAIL bounce_press: got rise=%0d down=%0d expected rise=1 down=0", rises, falls);
        end
        compared++;
        if (bus.db_out !== mDb) begin
            mismatched++;
            $display("[TB] FAIL bounce_model_db: got %0b expected %0b", bus.db_out, mDb);
        end
    endtask

    task automatic test_random();
        int cyc = 0;
        int len;
        while (cyc < 2000) begin
            bus.raw_in = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 7);
            for (int k = 0; k < len; k++) begin
                bus.glitch_clr = ($urandom_range(0, 39) == 0);
                rst = ($urandom_range(0, 299) == 0);
                step();
                cyc++;
                compared++;
                if (bus.db_out !== mDb) begin
                    mismatched++;
                    $display("[TB] FAIL rand_db@%0d: got %0b expected %0b", cyc, bus.db_out, mDb);
                end
                compared++;
                if (bus.busy !== mBusy) begin
                    mismatched++;
                    $display("[TB] FAIL rand_busy@%0d: got %0b expected %0b", cyc, bus.busy, mBusy);
                end
                compared++;
                if (bus.glitch_cnt !== mGlitch[GW-1:0]) begin
                    mismatched++;
                    $display("[TB] FAIL rand_glitch@%0d: got %0d expected %0d", cyc, bus.glitch_cnt, mGlitch);
                end
            end
        end
        rst = 1'b0;
        bus.glitch_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_press();
        test_glitch();
        test_saturation_clear();
        test_reset_mid_qualify();
        test_bounce();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
